// File: rtl/dpram_fifo_ctrl_if.sv
// Stream and RAM-port bundle for the dual-port-RAM FIFO controller.
// slave = controller side, master = environment side (source, sink, RAM).
interface dpram_fifo_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W+1:0] level;
  logic              ram_wr_en_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_in_a;
  logic              ram_wr_en_b;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_in_b;
  logic [DATA_W-1:0] ram_data_out_b;

  modport slave (
    input  in_valid, in_data, out_ready, ram_data_out_b,
    output in_ready, out_valid, out_data, level,
           ram_wr_en_a, ram_addr_a, ram_data_in_a,
           ram_wr_en_b, ram_addr_b, ram_data_in_b
  );

  modport master (
    output in_valid, in_data, out_ready, ram_data_out_b,
    input  in_ready, out_valid, out_data, level,
           ram_wr_en_a, ram_addr_a, ram_data_in_a,
           ram_wr_en_b, ram_addr_b, ram_data_in_b
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Stream FIFO controller in front of a dual-port RAM with registered read.
// Port A writes at wr_ptr, port B reads at rd_ptr; read data is prefetched
// into a 2-entry skid so the output side can pop every cycle without bubbles.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  dpram_fifo_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              rd_pend;
  logic [DATA_W-1:0] skid_mem [2];
  logic              skid_head;
  logic [1:0]        skid_cnt;

  logic              push;
  logic              pop;
  logic              rd_issue;
  logic [2:0]        skid_occ;
  logic              skid_wr_idx;

  // Handshakes, read-issue decision and RAM port drive
  always_comb begin
    bus.in_ready  = (ram_cnt < DEPTH_C);
    push          = bus.in_valid & bus.in_ready;
    bus.out_valid = (skid_cnt != 2'd0);
    pop           = bus.out_valid & bus.out_ready;
    // Skid slots already spoken for after this cycle's pop; a new read is
    // only issued if its data is guaranteed a slot when it returns.
    skid_occ      = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};
    rd_issue      = (ram_cnt != '0) && (skid_occ < 3'd2);
    // Tail slot is computed before the pop; when full, that is the slot the
    // pop frees, so the new word lands behind the remaining entry.
    skid_wr_idx   = skid_head ^ skid_cnt[0];

    bus.out_data      = skid_mem[skid_head];
    bus.level         = {1'b0, ram_cnt} + (ADDR_W+2)'(rd_pend) + (ADDR_W+2)'(skid_cnt);
    bus.ram_wr_en_a   = push;
    bus.ram_addr_a    = wr_ptr;
    bus.ram_data_in_a = bus.in_data;
    bus.ram_wr_en_b   = 1'b0;
    bus.ram_addr_b    = rd_ptr;
    bus.ram_data_in_b = '0;
  end

  // RAM pointers, RAM occupancy and outstanding-read flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      ram_cnt <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(rd_issue);
      rd_pend <= rd_issue;
    end
  end

  // Skid buffer: capture returning read data, advance head on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      skid_head   <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      if (rd_pend) skid_mem[skid_wr_idx] <= bus.ram_data_out_b;
      if (pop)     skid_head <= ~skid_head;
      skid_cnt <= skid_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end
endmodule
